status_register_unit: RTL and testbench
=======================================

// Module: status_register_unit
// PURPOSE
//   6502 processor status register (P). Sits directly downstream of alu: consumes
//   ALU_flags_output under a per-bit update mask. Also owns explicit flag ops
//   (CLC/SEC/CLI/SEI/CLD/SED/CLV), N/Z generation for load/transfer results,
//   PLP/RTI load, and PHP/BRK/IRQ push byte. Provides a delayed I copy for IRQ sampling.
// PARAMETERS
//   RESET_P         8'h24  P value after reset (I=1, bit5=1); bit5 forced 1, bit4 forced 0 regardless
//   IRQ_MASK_DELAY  1      0: irq_mask = P[I] combinationally; 1: irq_mask lags P[I] by one clk
// PORTS
//   clk          in   1  system clock, all state on rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   alu_flags    in   8  flags from alu, bit layout per status_register.vh (C0 Z1 I2 D3 B4 -5 V6 N7)
//   alu_mask     in   8  1 = take that bit of alu_flags into P this cycle
//   flag_op      in   3  NOP/CLC/SEC/CLI/SEI/CLD/SED/CLV (codes in flag_ops.vh)
//   nz_load      in   1  update N,Z from nz_value (LDA/TAX/PLA etc.)
//   nz_value     in   8  result byte for N/Z: N=nz_value[7], Z=(nz_value==0)
//   p_load       in   1  load P from data_in (PLP/RTI)
//   data_in      in   8  byte pulled from stack
//   irq_entry    in   1  interrupt/BRK sequence sets I
//   push_b       in   1  B value for p_push (1 for PHP/BRK, 0 for IRQ/NMI)
//   p_out        out  8  current P; bit5=1, bit4=0 always
//   p_push       out  8  p_out with bit4=push_b, bit5=1 (stack write byte)
//   irq_mask     out  1  I as seen by IRQ sampling logic
// BEHAVIOUR
//   - Reset (async, rst_n=0): P<=RESET_P with bit5=1/bit4=0; irq_mask<=1; p_push=P|8'h30 w/ push_b.
//     Reset asserted mid-operation discards any pending update same cycle.
//   - One update per clk, fixed priority (higher wins whole cycle, lower sources ignored):
//       1 p_load:   P <= {data_in[7:6],1'b1,1'b0,data_in[3:0]}
//       2 merged:   per bit, apply in order alu_mask, then nz_load (N,Z), then flag_op,
//                   then irq_entry (I<=1); later source overrides earlier on same bit.
//     So SEC with alu_mask[C]=1 yields C=1; irq_entry with CLI yields I=1.
//   - Bits 4,5 never stored: alu_mask[5:4] and data_in[5:4] ignored.
//   - Latency: update visible on p_out the cycle after the enabling edge (registered).
//   - flag_op NOP and all masks zero, no loads: P holds.
//   - irq_mask, IRQ_MASK_DELAY=1: irq_mask <= P[I] each clk, i.e. CLI/SEI/PLP effect on
//     IRQ sampling appears one cycle after p_out changes (6502 delayed-I behaviour).
//     irq_entry bypasses delay: irq_mask<=1 on the same edge P[I] is set.
//   - p_push purely combinational from P and push_b; no state.
//   - Unknown flag_op codes (none beyond 3'b111 exist) treated as NOP.
// STRUCTURE
//   - Flag bit positions: existing status_register.vh (add BREAK/UNUSED defines if absent).
//   - flag_op encodings: new inc/flag_ops.vh (FOP_NOP=0,CLC,SEC,CLI,SEI,CLD,SED,CLV=7).
//   - Single module; N/Z detect inline (no sub-module warranted). One always_ff-style
//     block for P, one for irq_mask, combinational next-P merge.
// TESTING
//   1 rst_n=0 mid-run -> p_out=8'h24, irq_mask=1 immediately (async), p_push(push_b=1)=8'h34.
//   2 alu_flags=8'h81, alu_mask=8'h81 -> next p_out=8'hA5; alu_mask=8'h01 only -> N untouched.
//   3 flag_op=SEC with alu_flags[C]=0, alu_mask[C]=1 -> C=1; CLI with irq_entry -> I=1.
//   4 p_load, data_in=8'hFF -> p_out=8'hEF; p_push push_b=0 -> 8'hEF, push_b=1 -> 8'hFF;
//     simultaneous flag_op=CLC ignored (C stays 1).
//   5 nz_load nz_value=8'h00 -> Z=1,N=0; nz_value=8'h80 -> Z=0,N=1; other bits unchanged.
//   6 IRQ_MASK_DELAY=1: CLI at edge k -> p_out[I]=0 after k, irq_mask=0 only after k+1;
//     IRQ_MASK_DELAY=0 -> both fall after edge k.

Source files
------------

// File: rtl/status_register_unit_pkg.sv
// Shared definitions for the 6502 processor status register: flag bit
// positions, explicit flag-op encodings and small helpers for building P.
package status_register_unit_pkg;

    // Bit positions inside P (C0 Z1 I2 D3 B4 -5 V6 N7)
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    // Bits 4 (B) and 5 (unused) exist only on the stack copy, never in P
    localparam logic [7:0] STORED_BITS = 8'hCF;
    localparam logic [7:0] UNUSED_ONE  = 8'h20;

    // Explicit flag instructions; every 3-bit code is defined
    typedef enum logic [2:0] {
        FOP_NOP = 3'd0,
        FOP_CLC = 3'd1,
        FOP_SEC = 3'd2,
        FOP_CLI = 3'd3,
        FOP_SEI = 3'd4,
        FOP_CLD = 3'd5,
        FOP_SED = 3'd6,
        FOP_CLV = 3'd7
    } flag_op_e;

    // Normalise a P image: bit5 reads as 1, bit4 reads as 0
    function automatic logic [7:0] fix_p(input logic [7:0] value);
        return (value & STORED_BITS) | UNUSED_ONE;
    endfunction

    // Derive N and Z from a load/transfer result, leaving other bits alone
    function automatic logic [7:0] apply_nz(input logic [7:0] p, input logic [7:0] value);
        logic [7:0] r;
        r         = p;
        r[FLAG_N] = value[7];
        r[FLAG_Z] = (value == 8'h00);
        return r;
    endfunction

    // Apply one explicit set/clear instruction
    function automatic logic [7:0] apply_flag_op(input logic [7:0] p, input flag_op_e op);
        logic [7:0] r;
        r = p;
        case (op)
            FOP_CLC: r[FLAG_C] = 1'b0;
            FOP_SEC: r[FLAG_C] = 1'b1;
            FOP_CLI: r[FLAG_I] = 1'b0;
            FOP_SEI: r[FLAG_I] = 1'b1;
            FOP_CLD: r[FLAG_D] = 1'b0;
            FOP_SED: r[FLAG_D] = 1'b1;
            FOP_CLV: r[FLAG_V] = 1'b0;
            default: r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/status_register_unit.sv
// 6502 status register P. Merges ALU flags, N/Z from load results, explicit
// flag instructions and interrupt entry into one registered update per clock;
// PLP/RTI loads override everything. Also forms the pushed P byte and the
// I copy used by IRQ sampling (optionally one cycle late, as on a real 6502).
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter logic [7:0] RESET_P        = 8'h24,
    parameter bit         IRQ_MASK_DELAY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_flags,
    input  logic [7:0] alu_mask,
    input  logic [2:0] flag_op,
    input  logic       nz_load,
    input  logic [7:0] nz_value,
    input  logic       p_load,
    input  logic [7:0] data_in,
    input  logic       irq_entry,
    input  logic       push_b,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       irq_mask
);

    logic [7:0] p_reg;
    logic [7:0] p_next;
    logic [7:0] p_merged;

    // Next P: a stack load wins outright; otherwise sources layer per bit,
    // each later source overriding an earlier one on the same bit.
    always_comb begin
        p_merged = (p_reg & ~alu_mask) | (alu_flags & alu_mask);
        if (nz_load) begin
            p_merged = apply_nz(p_merged, nz_value);
        end
        p_merged = apply_flag_op(p_merged, flag_op_e'(flag_op));
        if (irq_entry) begin
            p_merged[FLAG_I] = 1'b1;
        end

        if (p_load) begin
            p_next = fix_p(data_in);
        end else begin
            p_next = fix_p(p_merged);
        end
    end

    // P register; reset discards whatever update was pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= fix_p(RESET_P);
        end else begin
            p_reg <= p_next;
        end
    end

    generate
        if (IRQ_MASK_DELAY) begin : g_delayed_i
            logic irq_mask_reg;

            // Delayed I: follows P[I] one clock late, except interrupt entry
            // masks immediately so a second IRQ cannot slip in.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    irq_mask_reg <= 1'b1;
                end else if (!p_load && irq_entry) begin
                    irq_mask_reg <= 1'b1;
                end else begin
                    irq_mask_reg <= p_reg[FLAG_I];
                end
            end

            assign irq_mask = irq_mask_reg;
        end else begin : g_direct_i
            assign irq_mask = p_reg[FLAG_I];
        end
    endgenerate

    assign p_out  = p_reg;
    assign p_push = {p_reg[FLAG_N], p_reg[FLAG_V], 1'b1, push_b, p_reg[FLAG_D:FLAG_C]};

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: directed cases followed by
// randomized traffic, compared against a bit-level reference model.
module tb_status_register_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_flags;
    logic [7:0] alu_mask;
    logic [2:0] flag_op;
    logic       nz_load;
    logic [7:0] nz_value;
    logic       p_load;
    logic [7:0] data_in;
    logic       irq_entry;
    logic       push_b;

    logic [7:0] p_out, p_push;
    logic       irq_mask;
    logic [7:0] p_out_nd, p_push_nd;
    logic       irq_mask_nd;

    int n_chk  = 0;
    int n_pass = 0;

    // reference state
    logic [7:0] m_p;
    logic       m_irq_d;

    always #5 clk = ~clk;

    status_register_unit #(.RESET_P(8'h24), .IRQ_MASK_DELAY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .alu_flags(alu_flags), .alu_mask(alu_mask),
        .flag_op(flag_op), .nz_load(nz_load), .nz_value(nz_value), .p_load(p_load),
        .data_in(data_in), .irq_entry(irq_entry), .push_b(push_b),
        .p_out(p_out), .p_push(p_push), .irq_mask(irq_mask)
    );

    status_register_unit #(.RESET_P(8'h24), .IRQ_MASK_DELAY(1'b0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .alu_flags(alu_flags), .alu_mask(alu_mask),
        .flag_op(flag_op), .nz_load(nz_load), .nz_value(nz_value), .p_load(p_load),
        .data_in(data_in), .irq_entry(irq_entry), .push_b(push_b),
        .p_out(p_out_nd), .p_push(p_push_nd), .irq_mask(irq_mask_nd)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference: what P becomes after the next edge, built bit by bit
    function automatic logic [7:0] model_next(input logic [7:0] cur);
        logic [7:0] r;
        if (p_load) begin
            r = data_in;
        end else begin
            for (int i = 0; i < 8; i++) r[i] = alu_mask[i] ? alu_flags[i] : cur[i];
            if (nz_load) begin
                r[7] = nz_value[7];
                r[1] = (nz_value == 8'd0);
            end
            case (flag_op)
                3'd1: r[0] = 1'b0;
                3'd2: r[0] = 1'b1;
                3'd3: r[2] = 1'b0;
                3'd4: r[2] = 1'b1;
                3'd5: r[3] = 1'b0;
                3'd6: r[3] = 1'b1;
                3'd7: r[6] = 1'b0;
                default: ;
            endcase
            if (irq_entry) r[2] = 1'b1;
        end
        r[5] = 1'b1;
        r[4] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] model_push(input logic [7:0] p, input logic b);
        logic [7:0] r;
        r    = p;
        r[5] = 1'b1;
        r[4] = b;
        return r;
    endfunction

    task automatic idle();
        alu_flags = 8'h00; alu_mask = 8'h00; flag_op = 3'd0; nz_load = 1'b0;
        nz_value  = 8'h00; p_load = 1'b0; data_in = 8'h00; irq_entry = 1'b0;
        push_b    = 1'b0;
    endtask

    // One clock with the currently driven inputs, checked before and after the edge
    task automatic step();
        logic [7:0] nxt;
        #1;
        chk("p_push", p_push, model_push(m_p, push_b));
        chk("p_push_nd", p_push_nd, model_push(m_p, push_b));
        nxt = model_next(m_p);
        @(posedge clk);
        #1;
        m_irq_d = (!p_load && irq_entry) ? 1'b1 : m_p[2];
        m_p     = nxt;
        chk("p_out", p_out, m_p);
        chk("irq_mask", {7'd0, irq_mask}, {7'd0, m_irq_d});
        chk("p_out_nd", p_out_nd, m_p);
        chk("irq_mask_nd", {7'd0, irq_mask_nd}, {7'd0, m_p[2]});
    endtask

    // Async reset asserted between edges with an update pending
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_p = 8'h24; m_irq_d = 1'b1;
        push_b = 1'b1;
        #1;
        chk("rst_p_out", p_out, 8'h24);
        chk("rst_irq_mask", {7'd0, irq_mask}, 8'h01);
        chk("rst_p_push", p_push, 8'h34);
        chk("rst_p_out_nd", p_out_nd, 8'h24);
        @(posedge clk);
        #1;
        chk("rst_hold_p_out", p_out, 8'h24);
        #2;
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        m_p = 8'h24; m_irq_d = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("reset_p_out", p_out, 8'h24);
        chk("reset_irq", {7'd0, irq_mask}, 8'h01);

        // ALU flags under mask
        alu_flags = 8'h81; alu_mask = 8'h81; step();
        chk("alu_full", p_out, 8'hA5);
        idle(); alu_flags = 8'h00; alu_mask = 8'h01; step();
        chk("alu_c_only", p_out, 8'hA4);

        // flag_op overrides ALU; irq_entry overrides CLI
        idle(); flag_op = 3'd2; alu_mask = 8'h01; step();
        chk("sec_over_alu", p_out, 8'hA5);
        idle(); flag_op = 3'd3; irq_entry = 1'b1; step();
        chk("cli_irq_entry", p_out, 8'hA5);
        chk("irq_entry_mask", {7'd0, irq_mask}, 8'h01);

        // stack load wins over CLC; push byte variants
        idle(); p_load = 1'b1; data_in = 8'hFF; flag_op = 3'd1; step();
        chk("plp_ff", p_out, 8'hEF);
        idle(); push_b = 1'b0; #1; chk("push_b0", p_push, 8'hEF);
        push_b = 1'b1; #1; chk("push_b1", p_push, 8'hFF);

        // N/Z from result byte
        idle(); nz_load = 1'b1; nz_value = 8'h00; step();
        chk("nz_zero", p_out, 8'h6F);
        idle(); nz_load = 1'b1; nz_value = 8'h80; step();
        chk("nz_neg", p_out, 8'hED);

        // Delayed I after CLI
        idle(); flag_op = 3'd3; step();
        chk("cli_p_out", p_out, 8'hE9);
        chk("cli_irq_delayed", {7'd0, irq_mask}, 8'h01);
        chk("cli_irq_direct", {7'd0, irq_mask_nd}, 8'h00);
        idle(); step();
        chk("cli_irq_late", {7'd0, irq_mask}, 8'h00);

        async_reset();
        step();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            alu_flags = 8'($urandom);
            alu_mask  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            flag_op   = 3'($urandom);
            nz_load   = 1'($urandom);
            nz_value  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            p_load    = ($urandom_range(0, 7) == 0);
            data_in   = 8'($urandom);
            irq_entry = ($urandom_range(0, 5) == 0);
            push_b    = 1'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
